multdiv_issue_ctrl: RTL and testbench
=====================================

// Module: multdiv_issue_ctrl
// PURPOSE
//  Initiator side of the multi-cycle mult/div handshake. Sits in the X stage.
//  Latches operands, pulses the unit's start strobe, and stalls F/D/X until the
//  unit reports ready.
//  Issues exactly one writeback: the result to rd, or a status code to $rstatus
//  on exception/timeout.
// PARAMETERS
//  TIMEOUT_CYCLES  40  max WAIT cycles before forced timeout exception
//  CNT_W           6   wait-counter width; TIMEOUT_CYCLES < 2**CNT_W required
//  MULT_CODE       4   status written on mult exception/timeout
//  DIV_CODE        5   status written on div exception/timeout
//  RSTATUS_REG     30  destination register index for status writes
// PORTS
//  clock          in   1   sole clock, rising edge
//  reset          in   1   synchronous, active-high
//  flush          in   1   sync abort of in-flight op (branch/jump squash)
//  issue_valid    in   1   X stage holds a mult/div instruction
//  issue_op       in   1   0=mult, 1=div
//  issue_a        in   32  operand A
//  issue_b        in   32  operand B
//  issue_rd       in   5   destination register
//  stall          out  1   freeze PC, F/D, D/X latches (combinational)
//  md_ctrl_MULT   out  1   1-cycle start pulse to unit, mult
//  md_ctrl_DIV    out  1   1-cycle start pulse to unit, div
//  md_operandA    out  32  latched operand A, stable from LAUNCH until IDLE
//  md_operandB    out  32  latched operand B, stable from LAUNCH until IDLE
//  md_result      in   32  unit result
//  md_exception   in   1   unit overflow/div-by-zero, valid with md_resultRDY
//  md_resultRDY   in   1   unit completion pulse
//  wb_valid       out  1   1-cycle regfile write enable
//  wb_rd          out  5   write register: issue_rd, or RSTATUS_REG on exception
//  wb_data        out  32  md_result, or MULT_CODE/DIV_CODE on exception
// BEHAVIOUR
//  Reset: state=IDLE; counter=0; all latches=0; every output=0.
//   Reset is honoured in any state and drops any op in flight.
//  FSM states: IDLE, LAUNCH, WAIT, WB (2-bit encoding).
//   IDLE:   issue_valid -> latch op/a/b/rd -> LAUNCH.
//   LAUNCH: assert md_ctrl_MULT or md_ctrl_DIV per latched op; counter=0 -> WAIT.
//           md_resultRDY is ignored in LAUNCH.
//   WAIT:   counter+1 each cycle.
//           md_resultRDY=1 -> capture md_result and md_exception -> WB.
//           Else counter==TIMEOUT_CYCLES-1 -> force exception -> WB.
//   WB:     wb_valid=1 for exactly this cycle -> IDLE.
//           issue_valid in WB is ignored: it is the same instruction, now leaving X.
//  Stall: stall = (IDLE & issue_valid) | LAUNCH | WAIT.
//   stall=0 in WB, so the instruction advances as it writes back.
//  Start strobes and wb_valid decode from state flops only; no glitches.
//  Exception (md_exception=1 or timeout):
//   wb_rd=RSTATUS_REG, wb_data=zero-extended MULT_CODE or DIV_CODE.
//   Otherwise wb_rd=latched rd, wb_data=md_result.
//  Latency: issue seen at cycle 0; start pulse at cycle 1; RDY at cycle k>=2;
//   wb_valid at cycle k+1. Minimum 3 cycles issue-to-writeback.
//  Flush: next state=IDLE from any state, with no wb_valid for the aborted op.
//   Priority: reset > flush > md_resultRDY > timeout > issue_valid.
//   A late RDY arriving in IDLE after a flush is ignored.
//  Operand registers load only on the IDLE->LAUNCH transition.
//  No arithmetic here besides the CNT_W-bit counter, which saturates, never wraps.
// STRUCTURE
//  Shared header multdiv_defs.vh: state encodings (S_IDLE..S_WB), MULT_CODE,
//   DIV_CODE, RSTATUS_REG. The ALU and the exception path reuse these.
//  One sub-module: md_timeout_counter (CNT_W up-counter with sync clear,
//   enable, terminal-count flag). Everything else is flat in this module:
//   FSM, operand/result dffe registers, output decode.
// TESTING
//  mult 7*6, RDY at cycle 4 -> pulse MULT@1; stall 0..4; wb_valid@5, rd=issue_rd, data=42.
//  div 100/0, RDY+exception@3 -> wb_valid@4, wb_rd=30, wb_data=5; stall released @4.
//  mult, RDY never arrives -> wb_valid at cycle TIMEOUT_CYCLES+2, wb_rd=30, wb_data=4.
//  div, flush@2 then RDY@3 -> no wb_valid; stall=0 from cycle 3; state=IDLE.
//  Back-to-back mult then div in X -> two distinct start pulses; two wb_valid, one per op.
//   issue_valid during WB does not re-launch.
//  reset during WAIT, RDY next cycle -> all outputs 0; no wb_valid; operands cleared.

Source files
------------

// File: rtl/multdiv_issue_ctrl_pkg.sv
// Shared encodings for the mult/div issue controller:
// FSM states, op select and status writeback constants.
package multdiv_issue_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_WB     = 2'd3
    } md_state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int MD_MULT_CODE   = 4;
    localparam int MD_DIV_CODE    = 5;
    localparam int MD_RSTATUS_REG = 30;

endpackage

// File: rtl/multdiv_issue_ctrl_if.sv
// Issue, mult/div unit and writeback bundle of the X-stage controller.
// master = core/unit side, slave = controller side.
interface multdiv_issue_ctrl_if;

    logic        issue_valid;
    logic        issue_op;
    logic [31:0] issue_a;
    logic [31:0] issue_b;
    logic [4:0]  issue_rd;
    logic        stall;

    logic        md_ctrl_MULT;
    logic        md_ctrl_DIV;
    logic [31:0] md_operandA;
    logic [31:0] md_operandB;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_resultRDY;

    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    modport master (
        output issue_valid, issue_op, issue_a, issue_b, issue_rd,
        input  stall,
        input  md_ctrl_MULT, md_ctrl_DIV, md_operandA, md_operandB,
        output md_result, md_exception, md_resultRDY,
        input  wb_valid, wb_rd, wb_data
    );

    modport slave (
        input  issue_valid, issue_op, issue_a, issue_b, issue_rd,
        output stall,
        output md_ctrl_MULT, md_ctrl_DIV, md_operandA, md_operandB,
        input  md_result, md_exception, md_resultRDY,
        output wb_valid, wb_rd, wb_data
    );

endinterface

// File: rtl/multdiv_issue_ctrl_counter.sv
// Saturating wait counter with sync clear, enable and
// terminal-count flag for the mult/div timeout.
module md_timeout_counter #(
    parameter int CNT_W = 6,
    parameter int TERM  = 39
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clock) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == CNT_W'(TERM));

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// X-stage initiator for the multi-cycle mult/div unit: launches the
// op, stalls the front end and issues exactly one writeback.
module multdiv_issue_ctrl
    import multdiv_issue_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 40,
    parameter int CNT_W          = 6,
    parameter int MULT_CODE      = MD_MULT_CODE,
    parameter int DIV_CODE       = MD_DIV_CODE,
    parameter int RSTATUS_REG    = MD_RSTATUS_REG
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    multdiv_issue_ctrl_if.slave  bus
);

    md_state_t   r_state;
    logic        r_op;
    logic [4:0]  r_rd;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_result;
    logic        r_exc;

    logic        w_launch;
    logic        w_wait;
    logic        w_wb;
    logic        w_tc;

    assign w_launch = (r_state == S_LAUNCH);
    assign w_wait   = (r_state == S_WAIT);
    assign w_wb     = (r_state == S_WB);

    md_timeout_counter #(
        .CNT_W (CNT_W),
        .TERM  (TIMEOUT_CYCLES - 1)
    ) u_timeout (
        .clock (clock),
        .reset (reset),
        .i_clr (w_launch),
        .i_en  (w_wait),
        .o_tc  (w_tc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_op     <= OP_MULT;
            r_rd     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_exc    <= 1'b0;
        end else if (flush) begin
            r_state <= S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.issue_valid) begin
                        r_op    <= bus.issue_op;
                        r_rd    <= bus.issue_rd;
                        r_a     <= bus.issue_a;
                        r_b     <= bus.issue_b;
                        r_state <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // A real completion wins over a same-cycle timeout.
                    if (bus.md_resultRDY) begin
                        r_result <= bus.md_result;
                        r_exc    <= bus.md_exception;
                        r_state  <= S_WB;
                    end else if (w_tc) begin
                        r_exc   <= 1'b1;
                        r_state <= S_WB;
                    end
                end
                S_WB: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.stall = ((r_state == S_IDLE) && bus.issue_valid)
                     || w_launch || w_wait;

    assign bus.md_ctrl_MULT = w_launch && (r_op == OP_MULT);
    assign bus.md_ctrl_DIV  = w_launch && (r_op == OP_DIV);
    assign bus.md_operandA  = r_a;
    assign bus.md_operandB  = r_b;

    assign bus.wb_valid = w_wb;
    assign bus.wb_rd    = !w_wb ? 5'd0
                        : r_exc ? 5'(RSTATUS_REG)
                        : r_rd;
    assign bus.wb_data  = !w_wb ? 32'd0
                        : !r_exc ? r_result
                        : (r_op == OP_DIV) ? 32'(DIV_CODE)
                        : 32'(MULT_CODE);

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Directed bench for multdiv_issue_ctrl: latency, exception,
// timeout, flush, back-to-back and reset behaviour.
module tb_multdiv_issue_ctrl;

    logic clock;
    logic reset;
    logic flush;
    int   n_checks;
    int   n_fail;

    multdiv_issue_ctrl_if bus ();

    multdiv_issue_ctrl #(
        .TIMEOUT_CYCLES (40),
        .CNT_W          (6),
        .MULT_CODE      (4),
        .DIV_CODE       (5),
        .RSTATUS_REG    (30)
    ) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.issue_valid  = 1'b0;
        bus.issue_op     = 1'b0;
        bus.issue_a      = 32'd0;
        bus.issue_b      = 32'd0;
        bus.issue_rd     = 5'd0;
        bus.md_result    = 32'd0;
        bus.md_exception = 1'b0;
        bus.md_resultRDY = 1'b0;
        flush            = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " stall"}, 32'(bus.stall), 32'd0);
        check({tag, " mult"}, 32'(bus.md_ctrl_MULT), 32'd0);
        check({tag, " div"}, 32'(bus.md_ctrl_DIV), 32'd0);
        check({tag, " opA"}, bus.md_operandA, 32'd0);
        check({tag, " opB"}, bus.md_operandB, 32'd0);
        check({tag, " wbv"}, 32'(bus.wb_valid), 32'd0);
        check({tag, " wbrd"}, 32'(bus.wb_rd), 32'd0);
        check({tag, " wbdata"}, bus.wb_data, 32'd0);
    endtask

    // Cycle 0 = first cycle issue_valid is seen in IDLE.
    task automatic do_op(input string tag,
                         input logic op,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [4:0] rd,
                         input int rdy_at,
                         input logic exc,
                         input logic [31:0] res,
                         input int flush_at,
                         input int wb_at,
                         input logic [4:0] erd,
                         input logic [31:0] edata,
                         input int ncyc);
        int    end_c;
        string t;
        end_c = (flush_at >= 0) ? flush_at + 1 : wb_at;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clock);
            #1;
            bus.issue_valid  = (flush_at >= 0) ? (c < flush_at) : (c <= wb_at);
            bus.issue_op     = op;
            bus.issue_a      = a;
            bus.issue_b      = b;
            bus.issue_rd     = rd;
            bus.md_resultRDY = (c == rdy_at);
            bus.md_exception = exc && (c == rdy_at);
            bus.md_result    = (c == rdy_at) ? res : 32'hdead_beef;
            flush            = (c == flush_at);
            @(negedge clock);
            t = $sformatf("%s@%0d", tag, c);
            check({t, " stall"}, 32'(bus.stall),
                  32'((flush_at >= 0) ? (c <= flush_at) : (c < wb_at)));
            check({t, " mult"}, 32'(bus.md_ctrl_MULT), 32'(c == 1 && op == 1'b0));
            check({t, " div"}, 32'(bus.md_ctrl_DIV), 32'(c == 1 && op == 1'b1));
            check({t, " wbv"}, 32'(bus.wb_valid), 32'(c == wb_at));
            if (c >= 1 && c <= end_c && c <= wb_at + ((flush_at >= 0) ? ncyc : 0)) begin
                check({t, " opA"}, bus.md_operandA, a);
                check({t, " opB"}, bus.md_operandB, b);
            end
            if (c == wb_at) begin
                check({t, " wbrd"}, 32'(bus.wb_rd), 32'(erd));
                check({t, " wbdata"}, bus.wb_data, edata);
            end
        end
        idle_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_all_zero("reset");
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check_all_zero("idle");

        do_op("mul7x6", 1'b0, 32'd7, 32'd6, 5'd9,
              4, 1'b0, 32'd42, -1, 5, 5'd9, 32'd42, 7);

        do_op("div100/0", 1'b1, 32'd100, 32'd0, 5'd11,
              3, 1'b1, 32'hffff_ffff, -1, 4, 5'd30, 32'd5, 6);

        do_op("mul_tmo", 1'b0, 32'd3, 32'd5, 5'd12,
              -1, 1'b0, 32'd0, -1, 42, 5'd30, 32'd4, 44);

        do_op("div_flush", 1'b1, 32'd81, 32'd9, 5'd13,
              3, 1'b0, 32'd9, 2, -1, 5'd0, 32'd0, 6);

        // Back-to-back: second op's cycle 0 follows the first's WB cycle.
        do_op("b2b_mul", 1'b0, 32'h1234, 32'h10, 5'd3,
              2, 1'b0, 32'h12340, -1, 3, 5'd3, 32'h12340, 4);
        do_op("b2b_div", 1'b1, 32'd50, 32'd7, 5'd4,
              3, 1'b0, 32'd7, -1, 4, 5'd4, 32'd7, 6);

        // Reset in WAIT, then a late RDY.
        for (int c = 0; c < 6; c++) begin
            @(posedge clock);
            #1;
            bus.issue_valid  = (c <= 3);
            bus.issue_op     = 1'b0;
            bus.issue_a      = 32'hA5A5_0001;
            bus.issue_b      = 32'h5A5A_0002;
            bus.issue_rd     = 5'd21;
            reset            = (c == 3);
            bus.md_resultRDY = (c == 4);
            bus.md_result    = 32'd99;
            @(negedge clock);
            if (c == 3) begin
                check("rst@3 stall", 32'(bus.stall), 32'd1);
                check("rst@3 opA", bus.md_operandA, 32'hA5A5_0001);
            end
            if (c >= 4) begin
                check_all_zero($sformatf("rst@%0d", c));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
